// File: rtl/font_pkg.sv
// Shared font constants: RAM slot addresses, code-point ranges, loader FSM states.
package font_pkg;

    // Fixed slots for the fallback glyphs
    localparam logic [6:0] MISSING_ADDR = 7'h11;
    localparam logic [6:0] REPLACE_ADDR = 7'h7F;

    // Code-point ranges that map onto RAM slots
    localparam logic [31:0] LATIN_LO    = 32'h0000_0020;
    localparam logic [31:0] LATIN_HI    = 32'h0000_007E;
    localparam logic [31:0] BLOCK_LO    = 32'h0000_2580;
    localparam logic [31:0] BLOCK_HI    = 32'h0000_259F;
    localparam logic [31:0] REPLACE_UCP = 32'h0000_FFFD;

    typedef enum logic [1:0] {
        IDLE,
        MAP,
        LINES,
        DONE
    } state_t;

endpackage

// File: rtl/ucp_map.sv
// Combinational code point to glyph slot mapping, shared by loader and reader.
module ucp_map
    import font_pkg::*;
#(
    parameter int UCPW  = 21,
    parameter int SLOTW = 7
) (
    input  logic [UCPW-1:0]  i_ucp,
    output logic             o_mapped,
    output logic [SLOTW-1:0] o_slot
);

    logic [31:0] w_ucp;

    assign w_ucp = 32'(i_ucp);

    // Range decode: Latin printable, block elements, replacement character
    always_comb begin
        o_mapped = 1'b0;
        o_slot   = '0;
        if (w_ucp >= LATIN_LO && w_ucp <= LATIN_HI) begin
            o_mapped = 1'b1;
            o_slot   = SLOTW'(w_ucp);
        end else if (w_ucp >= BLOCK_LO && w_ucp <= BLOCK_HI) begin
            o_mapped = 1'b1;
            o_slot   = SLOTW'(w_ucp - BLOCK_LO);
        end else if (w_ucp == REPLACE_UCP) begin
            o_mapped = 1'b1;
            o_slot   = SLOTW'(REPLACE_ADDR);
        end
    end

endmodule

// File: rtl/glyph_loader.sv
// Runtime font writer: takes a code point and HEIGHT pixel lines and writes
// them to the glyph RAM write port using the reader's slot mapping.
module glyph_loader
    import font_pkg::*;
#(
    parameter int FONT_COUNT = 128,
    parameter int HEIGHT     = 16,
    parameter int LSB        = 0,
    parameter int UCPW       = 21,
    parameter int WIDTH      = 8,
    parameter int ADDRW      = $clog2(HEIGHT * FONT_COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [UCPW-1:0]  cmd_ucp,
    input  logic             line_valid,
    output logic             line_ready,
    input  logic [WIDTH-1:0] line_data,
    output logic             ram_we,
    output logic [ADDRW-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SLOTW = (FONT_COUNT > 1) ? $clog2(FONT_COUNT) : 1;
    localparam int LINEW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [LINEW-1:0] LAST_LINE = LINEW'(HEIGHT - 1);

    state_t             r_state;
    logic [UCPW-1:0]    r_ucp;
    logic [SLOTW-1:0]   r_slot;
    logic               r_unmapped;
    logic [LINEW-1:0]   r_line;

    logic               r_cmd_ready;
    logic               r_line_ready;
    logic               r_ram_we;
    logic [ADDRW-1:0]   r_ram_addr;
    logic [WIDTH-1:0]   r_ram_data;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_mapped;
    logic [SLOTW-1:0]   w_slot;
    logic [WIDTH-1:0]   w_rev;
    logic [WIDTH-1:0]   w_wdata;
    logic [ADDRW-1:0]   w_addr;
    logic               w_line_hs;

    ucp_map #(
        .UCPW  (UCPW),
        .SLOTW (SLOTW)
    ) u_map (
        .i_ucp    (r_ucp),
        .o_mapped (w_mapped),
        .o_slot   (w_slot)
    );

    // Mirror the line so the reader's pixel order is preserved in RAM
    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign w_rev[gi] = line_data[WIDTH-1-gi];
    end

    assign w_wdata   = (LSB != 0) ? line_data : w_rev;
    assign w_addr    = ADDRW'(r_slot) * ADDRW'(HEIGHT) + ADDRW'(r_line);
    assign w_line_hs = line_valid & r_line_ready;

    // Load sequencer with registered handshake, write-port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ucp        <= '0;
            r_slot       <= '0;
            r_unmapped   <= 1'b0;
            r_line       <= '0;
            r_cmd_ready  <= 1'b0;
            r_line_ready <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_ucp       <= cmd_ucp;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= MAP;
                    end
                end
                MAP: begin
                    r_slot       <= w_slot;
                    r_unmapped   <= ~w_mapped;
                    r_line_ready <= 1'b1;
                    r_state      <= LINES;
                end
                LINES: begin
                    if (w_line_hs) begin
                        r_ram_we   <= ~r_unmapped;
                        r_ram_addr <= w_addr;
                        r_ram_data <= w_wdata;
                        if (r_line == LAST_LINE) begin
                            r_line       <= '0;
                            r_line_ready <= 1'b0;
                            r_done       <= 1'b1;
                            r_err        <= r_unmapped;
                            r_state      <= DONE;
                        end else begin
                            r_line <= r_line + LINEW'(1);
                        end
                    end
                end
                DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign line_ready = r_line_ready;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_data   = r_ram_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
